derandomizer: RTL

DERANDOMIZER -- requirements
Module: derandomizer

---
 rtl/derand_pkg.sv | 38 +++
 rtl/prbs15_nibble.sv | 20 ++
 rtl/derandomizer.sv | 117 +++++++++++
 3 files changed

// File: rtl/derand_pkg.sv
// rtl/derand_pkg.sv - shared PRBS-15 definitions for the randomizer/derandomizer pair
// Contents: PRBS width, tap indices, default seed, frame FSM states and the
// 4-step LFSR function. Bit 0 of a nibble is the first bit in time.
package derand_pkg;

    localparam int PRBS_W = 15;
    localparam int TAP_HI = 14;
    localparam int TAP_LO = 13;

    localparam logic [PRBS_W-1:0] SEED_DEFAULT = 15'b100101010000000;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic [PRBS_W-1:0] next;
        logic [3:0]        mask;
    } prbs_step_t;

    // Four serial steps of x^15+x^14+1; keystream bit i is the feedback of step i.
    function automatic prbs_step_t prbs_step4(input logic [PRBS_W-1:0] cur);
        prbs_step_t        r;
        logic [PRBS_W-1:0] s;
        logic              t;
        s      = cur;
        r.mask = '0;
        for (int i = 0; i < 4; i++) begin
            t         = s[TAP_HI] ^ s[TAP_LO];
            r.mask[i] = t;
            s         = {s[PRBS_W-2:0], t};
        end
        r.next = s;
        return r;
    endfunction

endpackage

// File: rtl/prbs15_nibble.sv
// rtl/prbs15_nibble.sv - combinational 4-step PRBS-15 keystream generator
// Ports:
//   lfsr      in  15  current LFSR state
//   lfsr_next out 15  state after four steps
//   mask      out  4  keystream nibble (bit 0 first in time)
module prbs15_nibble
    import derand_pkg::*;
(
    input  logic [PRBS_W-1:0] lfsr,
    output logic [PRBS_W-1:0] lfsr_next,
    output logic [3:0]        mask
);

    prbs_step_t step;

    assign step      = prbs_step4(lfsr);
    assign lfsr_next = step.next;
    assign mask      = step.mask;

endmodule

// File: rtl/derandomizer.sv
// rtl/derandomizer.sv - framed PRBS-15 nibble descrambler with one registered output stage
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load, seed_in[14:0]        frame-seed register update
//   s_valid/s_sop/s_eop/s_data upstream scrambled nibbles, s_ready back
//   m_valid/m_sop/m_eop/m_data downstream descrambled nibbles, m_ready in
//   frame_err                  one-cycle framing-error pulse
module derandomizer #(
    parameter logic [derand_pkg::PRBS_W-1:0] SEED_DEFAULT = derand_pkg::SEED_DEFAULT,
    parameter int                            MAX_NIBBLES  = 376
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [14:0] seed_in,
    input  logic        s_valid,
    input  logic        s_sop,
    input  logic        s_eop,
    input  logic [3:0]  s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic        m_sop,
    output logic        m_eop,
    output logic [3:0]  m_data,
    input  logic        m_ready,
    output logic        frame_err
);

    import derand_pkg::*;

    localparam int              CNT_W   = $clog2(MAX_NIBBLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NIBBLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    frame_state_t      state;
    logic [PRBS_W-1:0] lfsr;
    logic [PRBS_W-1:0] frame_seed;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              drop;
    logic [PRBS_W-1:0] lfsr_cur;
    logic [PRBS_W-1:0] lfsr_next;
    logic [3:0]        mask;
    logic [CNT_W-1:0]  count_next;
    logic              hit_max;
    logic              eop_out;

    // The output register is the only storage stage: it may take a new nibble
    // whenever it is empty or being drained this cycle.
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // Without a frame start there is nothing to descramble against.
    assign drop    = (state == IDLE) && !s_sop;

    // A seed loaded in the same cycle as a frame start must seed that frame.
    assign lfsr_cur = s_sop ? (load ? seed_in : frame_seed) : lfsr;

    prbs15_nibble u_prbs (
        .lfsr      (lfsr_cur),
        .lfsr_next (lfsr_next),
        .mask      (mask)
    );

    // Saturating nibble counter; reaching the limit always ends the frame,
    // so the hold branch only guards against wrap.
    always_comb begin
        count_next = count;
        if (s_sop) begin
            count_next = CNT_ONE;
        end else if (count != CNT_MAX) begin
            count_next = count + CNT_ONE;
        end
    end

    assign hit_max = (count_next == CNT_MAX);
    assign eop_out = s_eop || hit_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED_DEFAULT;
            frame_seed <= SEED_DEFAULT;
            count      <= '0;
            m_valid    <= 1'b0;
            m_sop      <= 1'b0;
            m_eop      <= 1'b0;
            m_data     <= 4'h0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (load) begin
                frame_seed <= seed_in;
            end
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept) begin
                if (drop) begin
                    frame_err <= 1'b1;
                end else begin
                    m_valid   <= 1'b1;
                    m_data    <= s_data ^ mask;
                    m_sop     <= s_sop;
                    m_eop     <= eop_out;
                    lfsr      <= lfsr_next;
                    count     <= count_next;
                    // Error on a restart inside a frame or on a forced end.
                    frame_err <= ((state == IN_FRAME) && s_sop) || (hit_max && !s_eop);
                    state     <= eop_out ? IDLE : IN_FRAME;
                end
            end
        end
    end

endmodule
